// File: rtl/seq_div_pkg.sv
// Shared definitions for the lab divider: FSM state encoding and default widths.
package seq_div_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        ITER = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } div_state_t;

    localparam int DIV_WIDTH = 8;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH + 1);

endpackage

// File: rtl/seq_div_step.sv
// One restoring-division step: trial subtract of the divisor magnitude from the
// shifted partial remainder, keeping the difference only when it does not borrow.
module div_step
    import seq_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] r_shift,
    input  logic [WIDTH-1:0] d_mag,
    output logic [WIDTH-1:0] r_next,
    output logic             q_bit
);

    logic [WIDTH:0] trial_s;

    // Trial subtract in WIDTH+1 bits; the top bit is the borrow.
    always_comb begin
        trial_s = {1'b0, r_shift} - {1'b0, d_mag};
        if (trial_s[WIDTH] == 1'b0) begin
            r_next = trial_s[WIDTH-1:0];
            q_bit  = 1'b1;
        end else begin
            r_next = r_shift;
            q_bit  = 1'b0;
        end
    end

endmodule

// File: rtl/seq_div.sv
// Sequential restoring divider. Divisor is loaded from S with LoadDivisor,
// dividend is taken from S when Run starts a division.
// Optional feature macro: SIGNED_DIV_EN (two's-complement operands, FIX state,
// truncating division, overflow flag). Without it the divider is unsigned.
module seq_div
    import seq_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Run,
    input  logic             LoadDivisor,
    input  logic [WIDTH-1:0] S,
    output logic [WIDTH-1:0] Qval,
    output logic [WIDTH-1:0] Rval,
    output logic [WIDTH-1:0] Dval,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero,
    output logic             Ovf
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_NEG   = {1'b1, {(WIDTH-1){1'b0}}};

    // Two's-complement negate, wrapping at WIDTH bits.
    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        negate = (~v) + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Operand magnitude fed to the iteration; -2^(WIDTH-1) maps to unsigned 2^(WIDTH-1).
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
`ifdef SIGNED_DIV_EN
        if (v[WIDTH-1] == 1'b1) begin
            magnitude = negate(v);
        end else begin
            magnitude = v;
        end
`else
        magnitude = v;
`endif
    endfunction

    div_state_t       state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dbz_q, dbz_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef SIGNED_DIV_EN
    logic             neg_q, neg_d;
`endif

    logic [WIDTH-1:0] r_shift_s;
    logic [WIDTH-1:0] r_step_s;
    logic             q_bit_s;

    assign r_shift_s = {r_q[WIDTH-2:0], q_q[WIDTH-1]};

    div_step #(.WIDTH(WIDTH)) u_step (
        .r_shift (r_shift_s),
        .d_mag   (magnitude(d_q)),
        .r_next  (r_step_s),
        .q_bit   (q_bit_s)
    );

    // Next-state and datapath updates for the divide sequence.
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        r_d     = r_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;
`ifdef SIGNED_DIV_EN
        neg_d   = neg_q;
`endif
        case (state_q)
            IDLE: begin
                if (Run) begin
                    state_d = LOAD;
                end else if (LoadDivisor) begin
                    d_d = S;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                q_d     = magnitude(S);
                r_d     = {WIDTH{1'b0}};
                cnt_d   = {CNT_W{1'b0}};
                dbz_d   = (d_q == {WIDTH{1'b0}});
                ovf_d   = 1'b0;
`ifdef SIGNED_DIV_EN
                neg_d   = S[WIDTH-1];
`endif
                state_d = ITER;
            end
            ITER: begin
                r_d   = r_step_s;
                q_d   = {q_q[WIDTH-2:0], q_bit_s};
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                if (cnt_q == LAST_STEP) begin
`ifdef SIGNED_DIV_EN
                    state_d = FIX;
`else
                    state_d = DONE;
`endif
                end else begin
                    state_d = ITER;
                end
            end
            FIX: begin
`ifdef SIGNED_DIV_EN
                // A zero divisor leaves the all-ones quotient un-negated.
                if ((neg_q ^ d_q[WIDTH-1]) && !dbz_q) begin
                    q_d = negate(q_q);
                end else begin
                    q_d = q_q;
                end
                if (neg_q) begin
                    r_d = negate(r_q);
                end else begin
                    r_d = r_q;
                end
                // Magnitude quotient 2^(WIDTH-1) with divisor -1 only arises from MIN/-1.
                ovf_d = neg_q && (d_q == {WIDTH{1'b1}}) && (q_q == MIN_NEG);
`endif
                state_d = DONE;
            end
            DONE: begin
                if (Run) begin
                    state_d = DONE;
                end else begin
                    state_d = IDLE;
                end
                if (LoadDivisor) begin
                    d_d = S;
                end else begin
                    d_d = d_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == LOAD) || (state_d == ITER) || (state_d == FIX);
        done_d = (state_d == DONE);
    end

    // State and datapath registers; Reset clears everything asynchronously.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            q_q     <= {WIDTH{1'b0}};
            r_q     <= {WIDTH{1'b0}};
            d_q     <= {WIDTH{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SIGNED_DIV_EN
            neg_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            r_q     <= r_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SIGNED_DIV_EN
            neg_q   <= neg_d;
`endif
        end
    end

    assign Qval      = q_q;
    assign Rval      = r_q;
    assign Dval      = d_q;
    assign Busy      = busy_q;
    assign Done      = done_q;
    assign DivByZero = dbz_q;
    assign Ovf       = ovf_q;

endmodule

// File: doc/seq_div.md
Name: seq_div

Overview:
- Sequential restoring divider: the inverse of the team's shift-add multiplier.
- Divisor and dividend arrive over the same slider bus S. Quotient and remainder are built by repeated shift/trial-subtract.
- Sits in the lab top level beside the multiplier, behind the same button/switch synchronizers. Hex display drivers live outside the block.

Parameters:
- WIDTH, 8, operand, quotient and remainder width.

Ports:
- Clk  input  1  system clock
- Reset  input  1  asynchronous, active-high reset
- Run  input  1  synchronized, active-high start level
- LoadDivisor  input  1  synchronized, active-high; loads S into the divisor register
- S  input  WIDTH  synchronized switch data (dividend or divisor)
- Qval  output  WIDTH  quotient register
- Rval  output  WIDTH  remainder register
- Dval  output  WIDTH  divisor register
- Busy  output  1  high in LOAD/ITER/FIX
- Done  output  1  high in DONE
- DivByZero  output  1  divisor was 0 for the last division
- Ovf  output  1  signed overflow (-2^(WIDTH-1) / -1); tied 0 without SIGNED_DIV_EN

Behaviour:
- Reset: every output and internal register is 0; state is IDLE. Reset has priority over everything, including mid-operation.
- States: IDLE, LOAD, ITER, FIX, DONE.
- IDLE:
  - LoadDivisor=1 sets Dval<=S.
  - Run=1 goes to LOAD. Run has priority if both are high, and the divisor is not loaded that cycle.
- LOAD, one cycle:
  - Q<=magnitude(S), R<=0, count<=0.
  - DivByZero<=(Dval==0); Ovf<=0.
  - Next state ITER.
- ITER, one cycle per step, WIDTH steps:
  - Form {R,Q} shifted left by 1.
  - trial = {1'b0,Rshift} - {1'b0,|D|}, computed in WIDTH+1 bits.
  - If trial[WIDTH]==0: R<=trial[WIDTH-1:0] and Q[0]<=1. Otherwise R<=Rshift and Q[0]<=0.
  - count++. After step WIDTH, go to FIX if SIGNED_DIV_EN, else DONE.
- Latency: counting the edge that samples Run as edge 0, Done is high after edge WIDTH+1 (unsigned) or WIDTH+2 (signed).
- DONE:
  - Results held; Done=1.
  - Stays in DONE while Run=1, so holding the button never restarts.
  - Run=0 returns to IDLE with results retained until the next LOAD.
  - LoadDivisor is honoured in DONE and does not alter Qval/Rval.
- LoadDivisor is ignored while Busy.
- Divide by zero needs no special path: the iteration naturally yields Q=all ones and R=dividend magnitude. DivByZero=1. Latency is unchanged.
- Qval/Rval show intermediate values during ITER. They are valid only when Done=1.

Optional Feature:
- Macro SIGNED_DIV_EN.
- Defined:
  - Operands are two's complement.
  - LOAD and ITER use magnitudes; |-2^(WIDTH-1)| is represented as unsigned 2^(WIDTH-1).
  - FIX state (one cycle):
    - Q<=-Q if sign(dividend) XOR sign(divisor).
    - R<=-R if dividend is negative.
    - Truncating division.
  - Dividend sign is latched in LOAD.
  - Ovf<=1 when dividend=100..0 and divisor=all ones; Q=100..0.
  - DivByZero with a negative dividend: Q=all ones, R=dividend, with no quotient negation.
- Undefined:
  - Unsigned operation; no FIX state.
  - Ovf is constant 0.

Decomposition:
- Shared package (lab-wide):
  - div_state_t enum {IDLE, LOAD, ITER, FIX, DONE}
  - DIV_WIDTH=8
  - DIV_CNT_W=$clog2(DIV_WIDTH+1)
- One sub-module, div_step: combinational trial subtract. Takes Rshift and D; returns the next R and the quotient bit.
- Registers and the FSM stay in seq_div.

Test Plan:
- Unsigned 100/7: LoadDivisor with S=0x07, then Run with S=0x64 -> Qval=0x0E, Rval=0x02, Done high after edge 9, Busy low.
- Edge cases 0xFF/0x01 and 0x05/0x09 -> Q=0xFF/R=0x00; Q=0x00/R=0x05.
- Divide by zero: D=0x00, S=0x2A -> Q=0xFF, R=0x2A, DivByZero=1, same latency.
- SIGNED_DIV_EN:
  - 0xF9/0x02 -> Q=0xFD, R=0xFF, Done after edge 10.
  - 0x80/0xFF -> Q=0x80, Ovf=1.
- Reset asserted at edge 4 (mid ITER) -> all outputs 0 immediately, state IDLE; the next Run completes 100/7 correctly with D reloaded.
- Run held high for 20 cycles -> single division, Done stays 1. LoadDivisor pulsed during ITER -> Dval unchanged. Run released -> IDLE with results kept.
